// File: rtl/fetch_decode.sv
// ---------------------------------------------------------------------------
// fetch_decode
//   Byte-serial instruction fetcher and decoder. It reads one opcode byte,
//   then any operand bytes, from a byte-wide memory port. Each complete
//   instruction is presented to the control unit for one unstalled cycle.
//
//   An illegal opcode parks the block in HALT with a sticky fault. Only rst
//   leaves HALT.
//
// Ports
//   clk, rst          : clock; synchronous active-high reset
//   en                : run enable, sampled only in IDLE and at ISSUE exit
//   stall             : holds the block in ISSUE with all outputs frozen
//   mem_rd, mem_addr  : byte read request and its address (address == pc)
//   mem_ready         : completes the pending read; mem_data valid
//   mem_data          : fetched byte
//   ctl_op            : decoded opcode in ISSUE, CTL_NOP otherwise
//   reg_sel, data_out : operands, updated only when an instruction issues
//   op_valid          : high in the issue cycle(s)
//   pc                : address of the next byte to fetch
//   fault             : sticky illegal-opcode flag
// ---------------------------------------------------------------------------
module fetch_decode #(
    localparam int unsigned AW = 17,
    localparam int unsigned BW = 8,
    localparam int unsigned RW = 6,
    localparam int unsigned DW = 64,
    parameter logic [AW-1:0] RESET_PC      = 17'h00000,
    parameter logic [BW-1:0] CTL_NOP       = 8'h00,
    parameter logic [BW-1:0] CTL_LOAD_IMM  = 8'h01,
    parameter logic [BW-1:0] CTL_READ_ADDR = 8'h02
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          stall,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ready,
    input  logic [BW-1:0] mem_data,
    output logic [BW-1:0] ctl_op,
    output logic [RW-1:0] reg_sel,
    output logic [DW-1:0] data_out,
    output logic          op_valid,
    output logic [AW-1:0] pc,
    output logic          fault
);

    // Operand byte index width: up to 8 immediate bytes.
    localparam int unsigned IW = 3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH_OP  = 3'd1,
        FETCH_REG = 3'd2,
        FETCH_IMM = 3'd3,
        ISSUE     = 3'd4,
        HALT      = 3'd5
    } state_t;

    state_t state_q, state_d;

    // Internal instruction context.
    logic [BW-1:0] op_q,      op_d;
    logic [RW-1:0] reg_acc_q, reg_acc_d;
    logic [DW-1:0] acc_q,     acc_d;
    logic [IW-1:0] idx_q,     idx_d;
    logic [IW-1:0] last_q,    last_d;

    // Next values of the registered outputs.
    logic [AW-1:0] pc_d;
    logic          mem_rd_d;
    logic          op_valid_d;
    logic [BW-1:0] ctl_op_d;
    logic [RW-1:0] reg_sel_d;
    logic [DW-1:0] data_out_d;
    logic          fault_d;

    function automatic logic is_fetch(input state_t s);
        return (s == FETCH_OP) || (s == FETCH_REG) || (s == FETCH_IMM);
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Fetch states advance only on mem_ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = FETCH_OP;
                end
            end
            FETCH_OP: begin
                if (mem_ready) begin
                    if (mem_data == CTL_NOP) begin
                        state_d = ISSUE;
                    end else if (mem_data == CTL_LOAD_IMM) begin
                        state_d = FETCH_REG;
                    end else if (mem_data == CTL_READ_ADDR) begin
                        state_d = FETCH_IMM;
                    end else begin
                        state_d = HALT;
                    end
                end
            end
            FETCH_REG: begin
                if (mem_ready) begin
                    state_d = FETCH_IMM;
                end
            end
            FETCH_IMM: begin
                if (mem_ready && (idx_q == last_q)) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    state_d = en ? FETCH_OP : IDLE;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output and datapath next values, derived from the current and next state
    // so that every output is a flop.
    always_comb begin
        pc_d       = pc;
        op_d       = op_q;
        reg_acc_d  = reg_acc_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        last_d     = last_q;
        reg_sel_d  = reg_sel;
        data_out_d = data_out;

        // Every completed byte read advances pc; 17-bit arithmetic wraps.
        if (is_fetch(state_q) && mem_ready) begin
            pc_d = pc + AW'(1);
        end

        case (state_q)
            FETCH_OP: begin
                if (mem_ready) begin
                    op_d      = mem_data;
                    reg_acc_d = '0;
                    acc_d     = '0;
                    idx_d     = '0;
                    last_d    = (mem_data == CTL_LOAD_IMM) ? IW'(7) : IW'(2);
                end
            end
            FETCH_REG: begin
                if (mem_ready) begin
                    reg_acc_d = mem_data[RW-1:0];
                end
            end
            FETCH_IMM: begin
                // Little-endian: byte k lands in bits [8k+7:8k].
                if (mem_ready) begin
                    acc_d[{idx_q, 3'b000} +: BW] = mem_data;
                    idx_d                        = idx_q + IW'(1);
                end
            end
            default: begin
            end
        endcase

        // Operands are committed together on entry to ISSUE, so the visible
        // values never show a partially assembled instruction.
        if ((state_q != ISSUE) && (state_d == ISSUE)) begin
            if (op_d == CTL_LOAD_IMM) begin
                reg_sel_d  = reg_acc_d;
                data_out_d = acc_d;
            end else if (op_d == CTL_READ_ADDR) begin
                reg_sel_d  = '0;
                data_out_d = {40'h0, acc_d[23:0]};
            end
        end

        mem_rd_d   = is_fetch(state_d);
        op_valid_d = (state_d == ISSUE);
        ctl_op_d   = op_valid_d ? op_d : CTL_NOP;
        fault_d    = (state_d == HALT);
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            op_q      <= CTL_NOP;
            reg_acc_q <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            last_q    <= '0;
            mem_rd    <= 1'b0;
            op_valid  <= 1'b0;
            ctl_op    <= CTL_NOP;
            reg_sel   <= '0;
            data_out  <= '0;
            fault     <= 1'b0;
        end else begin
            pc        <= pc_d;
            op_q      <= op_d;
            reg_acc_q <= reg_acc_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            mem_rd    <= mem_rd_d;
            op_valid  <= op_valid_d;
            ctl_op    <= ctl_op_d;
            reg_sel   <= reg_sel_d;
            data_out  <= data_out_d;
            fault     <= fault_d;
        end
    end

    assign mem_addr = pc;

endmodule

// File: tb/tb_fetch_decode.sv
// ---------------------------------------------------------------------------
// tb_fetch_decode
//   Scoreboard bench for fetch_decode. Expected issues are queued when a
//   program is loaded. Each one is checked when op_valid appears. A second
//   instance with RESET_PC = 17'h1FFFF covers pc wrap-around.
// ---------------------------------------------------------------------------
module tb_fetch_decode;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    logic        rst, en, stall, mem_ready;
    logic [7:0]  mem_data;
    logic        mem_rd, op_valid, fault;
    logic [16:0] mem_addr, pc;
    logic [7:0]  ctl_op;
    logic [5:0]  reg_sel;
    logic [63:0] data_out;

    fetch_decode dut (
        .clk(clk), .rst(rst), .en(en), .stall(stall),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data),
        .ctl_op(ctl_op), .reg_sel(reg_sel), .data_out(data_out),
        .op_valid(op_valid), .pc(pc), .fault(fault)
    );

    // Wrap-around instance
    logic        w_rst, w_en, w_stall, w_mem_ready;
    logic [7:0]  w_mem_data;
    logic        w_mem_rd, w_op_valid, w_fault;
    logic [16:0] w_mem_addr, w_pc;
    logic [7:0]  w_ctl_op;
    logic [5:0]  w_reg_sel;
    logic [63:0] w_data_out;

    fetch_decode #(.RESET_PC(17'h1FFFF)) u_wrap (
        .clk(clk), .rst(w_rst), .en(w_en), .stall(w_stall),
        .mem_rd(w_mem_rd), .mem_addr(w_mem_addr), .mem_ready(w_mem_ready), .mem_data(w_mem_data),
        .ctl_op(w_ctl_op), .reg_sel(w_reg_sel), .data_out(w_data_out),
        .op_valid(w_op_valid), .pc(w_pc), .fault(w_fault)
    );

    typedef struct {
        logic [7:0]  op;
        logic [5:0]  rs;
        logic [63:0] d;
        int          lat;
    } issue_t;

    issue_t      exp_q[$];
    logic [7:0]  mem [int];
    int          total = 0;
    int          bad = 0;
    int          ready_mode = 0;
    logic        ready_phase = 1'b0;
    int          rd_cycles = 0;
    int          stall_left = 0;
    int          stall_seen = 0;
    logic        prev_rd = 1'b0;
    logic        prev_ready = 1'b0;
    logic [16:0] prev_addr = '0;

    function automatic logic [7:0] rd_mem(input logic [16:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return 8'hEE;
    endfunction

    task automatic push(input logic [7:0] op, input logic [5:0] rs, input logic [63:0] d, input int lat);
        issue_t e;
        e.op = op; e.rs = rs; e.d = d; e.lat = lat;
        exp_q.push_back(e);
    endtask

    // One clock: observe at negedge, check issues, drive next inputs.
    task automatic tick();
        issue_t e;
        @(posedge clk);
        @(negedge clk);
        if (mem_rd === 1'b1) rd_cycles++;
        if (prev_rd === 1'b1 && prev_ready === 1'b0 && mem_rd === 1'b1) begin
            total++;
            if (mem_addr !== prev_addr) begin
                bad++;
                $display("FAIL addr_hold: mem_addr=%h required %h", mem_addr, prev_addr);
            end
        end
        stall = 1'b0;
        if (op_valid === 1'b1) begin
            total++;
            if (mem_rd !== 1'b0) begin
                bad++;
                $display("FAIL issue_mem_rd: mem_rd=%b required 0", mem_rd);
            end
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_issue: ctl_op=%h with nothing expected", ctl_op);
            end else begin
                e = exp_q[0];
                if ({ctl_op, reg_sel, data_out} !== {e.op, e.rs, e.d}) begin
                    bad++;
                    $display("FAIL issue_payload: got op=%h rs=%0d d=%h required op=%h rs=%0d d=%h",
                             ctl_op, reg_sel, data_out, e.op, e.rs, e.d);
                end
                if (stall_left > 0) begin
                    stall = 1'b1;
                    stall_left--;
                    stall_seen++;
                end else begin
                    e = exp_q.pop_front();
                    if (ready_mode == 0) begin
                        total++;
                        if (rd_cycles != e.lat) begin
                            bad++;
                            $display("FAIL latency: fetch cycles=%0d required %0d", rd_cycles, e.lat);
                        end
                    end
                    rd_cycles = 0;
                    en = (exp_q.size() != 0);
                end
            end
        end
        ready_phase = ~ready_phase;
        mem_ready = (ready_mode == 0) ? 1'b1 : ready_phase;
        mem_data = rd_mem(mem_addr);
        prev_rd = mem_rd;
        prev_ready = mem_ready;
        prev_addr = mem_addr;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; stall = 1'b0;
        stall_left = 0; stall_seen = 0;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        rd_cycles = 0;
    endtask

    task automatic run_issues(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout: %0d issues pending, required 0", name, exp_q.size());
        end
        tick();
        tick();
    endtask

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        tick();
        check_val("rst_mem_rd",   64'(mem_rd),   64'h0);
        check_val("rst_mem_addr", 64'(mem_addr), 64'h0);
        check_val("rst_pc",       64'(pc),       64'h0);
        check_val("rst_ctl_op",   64'(ctl_op),   64'h0);
        check_val("rst_reg_sel",  64'(reg_sel),  64'h0);
        check_val("rst_data_out", data_out,      64'h0);
        check_val("rst_op_valid", 64'(op_valid), 64'h0);
        check_val("rst_fault",    64'(fault),    64'h0);
        rst = 1'b0;
    endtask

    task automatic test_nop();
        do_reset();
        mem.delete();
        ready_mode = 0;
        mem[0] = 8'h00;
        push(8'h00, 6'd0, 64'h0, 1);
        en = 1'b1;
        run_issues("nop", 20);
        check_val("nop_pc", 64'(pc), 64'd1);
    endtask

    task automatic test_load_imm();
        logic [7:0] prog [10];
        prog = '{8'h01, 8'h05, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        do_reset();
        mem.delete();
        ready_mode = 0;
        for (int i = 0; i < 10; i++) mem[i] = prog[i];
        push(8'h01, 6'd5, 64'h1122334455667788, 10);
        en = 1'b1;
        run_issues("load_imm", 40);
        check_val("load_imm_pc", 64'(pc), 64'd10);
    endtask

    task automatic test_read_addr();
        do_reset();
        mem.delete();
        ready_mode = 1;
        mem[0] = 8'h02; mem[1] = 8'h34; mem[2] = 8'h12; mem[3] = 8'h01;
        push(8'h02, 6'd0, 64'h0000000000011234, 0);
        en = 1'b1;
        run_issues("read_addr", 40);
        check_val("read_addr_pc", 64'(pc), 64'd4);
        ready_mode = 0;
    endtask

    task automatic test_stall();
        do_reset();
        mem.delete();
        ready_mode = 0;
        mem[0] = 8'h02; mem[1] = 8'hAA; mem[2] = 8'hBB; mem[3] = 8'hCC;
        push(8'h02, 6'd0, 64'h0000000000CCBBAA, 4);
        stall_left = 3;
        en = 1'b1;
        run_issues("stall", 40);
        check_val("stall_cycles", 64'(stall_seen), 64'd3);
    endtask

    task automatic test_illegal();
        do_reset();
        mem.delete();
        ready_mode = 0;
        mem[0] = 8'h7F;
        en = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check_val("illegal_fault",  64'(fault),  64'h1);
        check_val("illegal_mem_rd", 64'(mem_rd), 64'h0);
        check_val("illegal_ctl_op", 64'(ctl_op), 64'h0);
        check_val("illegal_pc",     64'(pc),     64'd1);
        for (int i = 0; i < 4; i++) tick();
        check_val("illegal_sticky", 64'(fault),  64'h1);
        do_reset();
        check_val("illegal_rst_fault", 64'(fault), 64'h0);
        check_val("illegal_rst_pc",    64'(pc),    64'h0);
    endtask

    task automatic test_reset_mid_fetch();
        int guard;
        do_reset();
        mem.delete();
        ready_mode = 0;
        mem[0] = 8'h02; mem[1] = 8'h56; mem[2] = 8'h34; mem[3] = 8'h12;
        mem[4] = 8'h01; mem[5] = 8'h07;
        for (int i = 6; i < 14; i++) mem[i] = 8'(i);
        push(8'h02, 6'd0, 64'h0000000000123456, 4);
        en = 1'b1;
        run_issues("mid_pre", 30);
        en = 1'b1;
        guard = 0;
        while (pc !== 17'd9 && guard < 40) begin
            tick();
            guard++;
        end
        check_val("mid_reach_byte5", 64'(pc), 64'd9);
        do_reset();
        check_val("mid_data_out", data_out,      64'h0);
        check_val("mid_pc",       64'(pc),       64'h0);
        check_val("mid_op_valid", 64'(op_valid), 64'h0);
        push(8'h02, 6'd0, 64'h0000000000123456, 4);
        en = 1'b1;
        run_issues("mid_restart", 30);
    endtask

    task automatic test_back_to_back();
        do_reset();
        mem.delete();
        ready_mode = 0;
        mem[0] = 8'h01; mem[1] = 8'hC5;
        for (int i = 0; i < 8; i++) mem[2 + i] = 8'(8 - i);
        mem[10] = 8'h02; mem[11] = 8'hEF; mem[12] = 8'hBE; mem[13] = 8'hAD;
        mem[14] = 8'h00;
        push(8'h01, 6'd5, 64'h0102030405060708, 10);
        push(8'h02, 6'd0, 64'h0000000000ADBEEF, 4);
        push(8'h00, 6'd0, 64'h0000000000ADBEEF, 1);
        en = 1'b1;
        run_issues("b2b", 60);
        check_val("b2b_pc", 64'(pc), 64'd15);
    endtask

    task automatic test_wrap();
        int n_fetch = 0;
        int n_iss = 0;
        logic [16:0] fa [2];
        fa[0] = '0; fa[1] = '0;
        mem.delete();
        mem[17'h1FFFF] = 8'h00;
        mem[0] = 8'h00;
        @(negedge clk);
        check_val("wrap_rst_pc", 64'(w_pc), 64'h1FFFF);
        w_rst = 1'b0;
        w_en = 1'b1;
        w_mem_data = rd_mem(w_mem_addr);
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (w_mem_rd === 1'b1) begin
                if (n_fetch < 2) fa[n_fetch] = w_mem_addr;
                n_fetch++;
            end
            if (w_op_valid === 1'b1) begin
                n_iss++;
                if (n_iss == 2) w_en = 1'b0;
            end
            w_mem_data = rd_mem(w_mem_addr);
        end
        check_val("wrap_fetch0", 64'(fa[0]),   64'h1FFFF);
        check_val("wrap_fetch1", 64'(fa[1]),   64'h00000);
        check_val("wrap_nfetch", 64'(n_fetch), 64'd2);
        check_val("wrap_issues", 64'(n_iss),   64'd2);
        check_val("wrap_pc",     64'(w_pc),    64'd1);
        check_val("wrap_fault",  64'(w_fault), 64'h0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; stall = 1'b0; mem_ready = 1'b0; mem_data = 8'h00;
        w_rst = 1'b1; w_en = 1'b0; w_stall = 1'b0; w_mem_ready = 1'b1; w_mem_data = 8'h00;
        test_reset();
        test_nop();
        test_load_imm();
        test_read_addr();
        test_stall();
        test_illegal();
        test_reset_mid_fetch();
        test_back_to_back();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
